// File: rtl/thread_scheduler_pkg.sv
// thread_scheduler_pkg: definitions shared by the barrel-core thread scheduler
// and the fetch/mt_pc blocks.
//   - thr_state_t  : per-thread state encoding (IDLE / READY / WAIT)
//   - DEF_NUM_THREADS, DEF_WAIT_WIDTH : default thread count and stall counter width
package thread_scheduler_pkg;

    localparam int DEF_NUM_THREADS = 8;
    localparam int DEF_WAIT_WIDTH  = 4;

    typedef enum logic [1:0] {
        THR_IDLE  = 2'b00,
        THR_READY = 2'b01,
        THR_WAIT  = 2'b10
    } thr_state_t;

endpackage

// File: rtl/thread_scheduler_rr_pick.sv
// rr_pick: rotating priority encoder. Returns the first set bit of 'eligible'
// scanning last_tid+1, last_tid+2, ... with wrap-around. Purely combinational.
//   eligible [N-1:0]  in  : candidate mask
//   last_tid [BW-1:0] in  : most recent winner (scan starts just after it)
//   pick     [BW-1:0] out : winning index (0 when found=0)
//   found             out : at least one eligible bit set
module rr_pick #(
    parameter int N  = 8,
    parameter int BW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [BW-1:0] last_tid,
    output logic [BW-1:0] pick,
    output logic          found
);

    always_comb begin
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        // i = N covers last_tid itself, so a single eligible thread keeps winning.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_tid) + i) % N;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx[BW-1:0];
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin issue scheduler for the barrel core fetch stage.
// Keeps an IDLE/READY/WAIT state and a stall counter per thread and issues one
// READY thread id per enabled cycle; a bubble (tid_valid=0) when none is READY.
//   clk, rst (async, active high)
//   en                      : advance issue; 0 holds tid/tid_valid/last_tid
//   start/halt/wait/wake    : per-thread events (valid + tid), wait carries wait_cycles
//   tid, tid_valid          : registered issue output
//   ready_mask, active_mask : combinational view of per-thread state
//
// Handshake: the *_valid event inputs are single-cycle strobes sampled on every
// rising edge; there is no back-pressure, each strobe is consumed on the edge it
// is seen. tid is meaningful only while tid_valid=1.
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int NUM_THREADS  = DEF_NUM_THREADS,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int WAIT_WIDTH   = DEF_WAIT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start_valid,
    input  logic [BITS_THREADS-1:0] start_tid,
    input  logic                    halt_valid,
    input  logic [BITS_THREADS-1:0] halt_tid,
    input  logic                    wait_valid,
    input  logic [BITS_THREADS-1:0] wait_tid,
    input  logic [WAIT_WIDTH-1:0]   wait_cycles,
    input  logic                    wake_valid,
    input  logic [BITS_THREADS-1:0] wake_tid,
    output logic [BITS_THREADS-1:0] tid,
    output logic                    tid_valid,
    output logic [NUM_THREADS-1:0]  ready_mask,
    output logic [NUM_THREADS-1:0]  active_mask
);

    thr_state_t              state_q [NUM_THREADS];
    logic [WAIT_WIDTH-1:0]   cnt_q   [NUM_THREADS];
    logic [NUM_THREADS-1:0]  halt_hit, wait_hit, wake_hit, start_hit, eligible;
    logic [BITS_THREADS-1:0] last_tid, pick;
    logic                    found;
    logic [WAIT_WIDTH-1:0]   wait_len;

    // A zero-length stall still costs one cycle.
    assign wait_len = (wait_cycles == '0) ? WAIT_WIDTH'(1) : wait_cycles;

    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            halt_hit[i]    = halt_valid  && (halt_tid  == BITS_THREADS'(i));
            wait_hit[i]    = wait_valid  && (wait_tid  == BITS_THREADS'(i));
            wake_hit[i]    = wake_valid  && (wake_tid  == BITS_THREADS'(i));
            start_hit[i]   = start_valid && (start_tid == BITS_THREADS'(i));
            ready_mask[i]  = (state_q[i] == THR_READY);
            active_mask[i] = (state_q[i] != THR_IDLE);
        end
    end

    // A thread being halted or stalled this cycle must not be issued this cycle.
    assign eligible = ready_mask & ~halt_hit & ~wait_hit;

    rr_pick #(.N(NUM_THREADS), .BW(BITS_THREADS)) u_rr_pick (
        .eligible (eligible),
        .last_tid (last_tid),
        .pick     (pick),
        .found    (found)
    );

    // Per-thread state machines; priority halt > wait > wake > start > expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                state_q[i] <= (i == 0) ? THR_READY : THR_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (halt_hit[i]) begin
                    state_q[i] <= THR_IDLE;
                    cnt_q[i]   <= '0;
                end else if (wait_hit[i] && state_q[i] != THR_IDLE) begin
                    state_q[i] <= THR_WAIT;
                    cnt_q[i]   <= wait_len;
                end else if (wake_hit[i] && state_q[i] == THR_WAIT) begin
                    state_q[i] <= THR_READY;
                    cnt_q[i]   <= '0;
                end else if (start_hit[i] && state_q[i] == THR_IDLE) begin
                    state_q[i] <= THR_READY;
                end else if (state_q[i] == THR_WAIT) begin
                    if (cnt_q[i] > WAIT_WIDTH'(1)) begin
                        cnt_q[i] <= cnt_q[i] - WAIT_WIDTH'(1);
                    end else begin
                        state_q[i] <= THR_READY;
                        cnt_q[i]   <= '0;
                    end
                end
            end
        end
    end

    // Issue registers. last_tid resets to the top thread so thread 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tid       <= '0;
            tid_valid <= 1'b0;
            last_tid  <= BITS_THREADS'(NUM_THREADS - 1);
        end else if (en) begin
            if (found) begin
                tid       <= pick;
                tid_valid <= 1'b1;
                last_tid  <= pick;
            end else begin
                tid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: boot, round robin, timed stall,
// all-stalled bubbles with early wake, simultaneous events under en=0,
// and asynchronous reset during a stall.
module tb_thread_scheduler;

    localparam int NT = 8;
    localparam int BT = 3;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start_valid, halt_valid, wait_valid, wake_valid;
    logic [BT-1:0] start_tid, halt_tid, wait_tid, wake_tid;
    logic [WW-1:0] wait_cycles;
    logic [BT-1:0] tid;
    logic          tid_valid;
    logic [NT-1:0] ready_mask, active_mask;

    int checks = 0;
    int errors = 0;
    logic [BT-1:0] exp_q[$];

    thread_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start_valid (start_valid),
        .start_tid   (start_tid),
        .halt_valid  (halt_valid),
        .halt_tid    (halt_tid),
        .wait_valid  (wait_valid),
        .wait_tid    (wait_tid),
        .wait_cycles (wait_cycles),
        .wake_valid  (wake_valid),
        .wake_tid    (wake_tid),
        .tid         (tid),
        .tid_valid   (tid_valid),
        .ready_mask  (ready_mask),
        .active_mask (active_mask)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic clear_events();
        start_valid = 1'b0; start_tid = '0;
        halt_valid  = 1'b0; halt_tid  = '0;
        wait_valid  = 1'b0; wait_tid  = '0; wait_cycles = '0;
        wake_valid  = 1'b0; wake_tid  = '0;
    endtask

    // One rising edge; outputs are sampled at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        clear_events();
    endtask

    task automatic issue(input string tag, input logic [BT-1:0] exp_tid);
        step();
        check({tag, "_valid"}, 32'(tid_valid), 32'(1));
        check(tag, 32'(tid), 32'(exp_tid));
    endtask

    task automatic bubble(input string tag, input logic [BT-1:0] held_tid);
        step();
        check({tag, "_valid"}, 32'(tid_valid), 32'(0));
        check({tag, "_held"}, 32'(tid), 32'(held_tid));
    endtask

    // Drains exp_q, one expected issue per cycle.
    task automatic issue_seq(input string tag);
        while (exp_q.size() > 0) issue(tag, exp_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        en  = 1'b1;
        clear_events();
        repeat (2) @(negedge clk);
        check("rst_tid",    32'(tid),         32'(0));
        check("rst_valid",  32'(tid_valid),   32'(0));
        check("rst_ready",  32'(ready_mask),  32'h01);
        check("rst_active", 32'(active_mask), 32'h01);
        rst = 1'b0;

        // Boot: only thread 0 runs.
        exp_q = '{3'd0, 3'd0, 3'd0};
        issue_seq("boot");
        check("boot_ready", 32'(ready_mask), 32'h01);

        // Round robin: start 1, 2, 3 on consecutive cycles.
        start_valid = 1'b1; start_tid = 3'd1; issue("rr", 3'd0);
        start_valid = 1'b1; start_tid = 3'd2; issue("rr", 3'd1);
        start_valid = 1'b1; start_tid = 3'd3; issue("rr", 3'd2);
        issue("rr", 3'd3);
        check("rr_active", 32'(active_mask), 32'h0F);
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3};
        issue_seq("rr");

        // Timed stall: thread 2 waits 3 cycles.
        wait_valid = 1'b1; wait_tid = 3'd2; wait_cycles = 4'd3;
        issue("stall", 3'd0);
        check("stall_ready_w", 32'(ready_mask), 32'h0B);
        exp_q = '{3'd1, 3'd3, 3'd0};
        issue_seq("stall");
        check("stall_ready_r", 32'(ready_mask), 32'h0F);
        exp_q = '{3'd1, 3'd2, 3'd3};
        issue_seq("stall");

        // wait_cycles=0 acts as a 1-cycle stall.
        wait_valid = 1'b1; wait_tid = 3'd2; wait_cycles = 4'd0;
        issue("wait0", 3'd0);
        check("wait0_ready_w", 32'(ready_mask), 32'h0B);
        issue("wait0", 3'd1);
        check("wait0_ready_r", 32'(ready_mask), 32'h0F);
        issue("wait0", 3'd2);

        // Reduce to thread 0 only.
        halt_valid = 1'b1; halt_tid = 3'd1; issue("halt", 3'd3);
        halt_valid = 1'b1; halt_tid = 3'd2; issue("halt", 3'd0);
        halt_valid = 1'b1; halt_tid = 3'd3; issue("halt", 3'd0);
        check("halt_active", 32'(active_mask), 32'h01);

        // All stalled: thread 0 waits 4 -> 5 bubbles, then reissue.
        wait_valid = 1'b1; wait_tid = 3'd0; wait_cycles = 4'd4;
        bubble("allst", 3'd0);
        check("allst_active", 32'(active_mask), 32'h01);
        check("allst_ready",  32'(ready_mask),  32'h00);
        repeat (4) bubble("allst", 3'd0);
        issue("allst", 3'd0);

        // Early wake in the 2nd stall cycle -> reissue 2 cycles later.
        wait_valid = 1'b1; wait_tid = 3'd0; wait_cycles = 4'd4;
        bubble("wake", 3'd0);
        bubble("wake", 3'd0);
        wake_valid = 1'b1; wake_tid = 3'd0;
        bubble("wake", 3'd0);
        issue("wake", 3'd0);

        // Simultaneous events with en=0.
        start_valid = 1'b1; start_tid = 3'd1; issue("sim", 3'd0);
        issue("sim", 3'd1);
        en = 1'b0;
        halt_valid  = 1'b1; halt_tid = 3'd1;
        wait_valid  = 1'b1; wait_tid = 3'd1; wait_cycles = 4'd5;
        start_valid = 1'b1; start_tid = 3'd5;
        issue("sim_hold", 3'd1);
        check("sim_ready",  32'(ready_mask),  32'h21);
        check("sim_active", 32'(active_mask), 32'h21);
        issue("sim_hold", 3'd1);
        en = 1'b1;
        exp_q = '{3'd5, 3'd0, 3'd5};
        issue_seq("sim");

        // Put threads 2 and 3 into long stalls, then reset asynchronously.
        start_valid = 1'b1; start_tid = 3'd2; issue("mid", 3'd0);
        start_valid = 1'b1; start_tid = 3'd3; issue("mid", 3'd2);
        wait_valid = 1'b1; wait_tid = 3'd2; wait_cycles = 4'd8; issue("mid", 3'd3);
        wait_valid = 1'b1; wait_tid = 3'd3; wait_cycles = 4'd8; issue("mid", 3'd5);
        check("mid_active", 32'(active_mask), 32'h2D);
        check("mid_ready",  32'(ready_mask),  32'h21);
        #2 rst = 1'b1;
        #1;
        check("arst_tid",    32'(tid),         32'(0));
        check("arst_valid",  32'(tid_valid),   32'(0));
        check("arst_active", 32'(active_mask), 32'h01);
        check("arst_ready",  32'(ready_mask),  32'h01);
        @(negedge clk);
        rst = 1'b0;
        exp_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        issue_seq("post_rst");
        check("post_rst_active", 32'(active_mask), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
